// File: rtl/to_upper_pkg.sv
// Shared types and constants for the toUpper stream arbiter.
package to_upper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] LOWER_A     = 8'h61;
  localparam logic [7:0] LOWER_Z     = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  // True for ASCII 'a'..'z'.
  function automatic logic is_lower(input logic [7:0] b);
    return (b >= LOWER_A) && (b <= LOWER_Z);
  endfunction

endpackage

// File: rtl/to_upper_stream_arbiter_to_upper.sv
// Combinational ASCII toUpper converter. Every lowercase letter has the form
// 011x_xxxx, so subtracting CASE_OFFSET is the same as clearing bit 5.
module to_upper_stream_arbiter_to_upper
  import to_upper_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic lower;

  assign lower = is_lower(din);
  assign dout  = {din[7:6], din[5] & ~lower, din[4:0]};

endmodule

// File: rtl/to_upper_stream_arbiter.sv
// Two-channel byte-stream arbiter sharing one toUpper converter.
// Round-robin bursts end at a line feed, after MAX_BURST bytes, or when the
// granted requester goes idle. Optional conversion statistics are built when
// the macro UPPER_STATS_EN is defined.
module to_upper_stream_arbiter
  import to_upper_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_valid,
  input  logic [7:0]       in_data0,
  input  logic [7:0]       in_data1,
  output logic [1:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_id
`ifdef UPPER_STATS_EN
  ,
  output logic [CNT_W-1:0] conv_cnt0,
  output logic [CNT_W-1:0] conv_cnt1
`endif
);

  localparam logic [7:0] MAX_B8 = 8'(MAX_BURST);

  // Reject illegal configurations at elaboration time.
  if (MAX_BURST < 1 || MAX_BURST > 255 || CNT_W < 1) begin : g_bad_param
    $error("to_upper_stream_arbiter: illegal MAX_BURST or CNT_W");
  end

  state_t     state_reg;
  logic       rr_ptr_reg;
  logic [7:0] burst_cnt_reg;
  logic       out_valid_reg;
  logic [7:0] out_data_reg;
  logic       out_id_reg;

  logic       granted;
  logic       grant_ch;
  logic       out_free;
  logic       xfer;
  logic       burst_end;
  logic       idle_end;
  logic [7:0] sel_data;
  logic [7:0] conv_data;

  assign granted  = (state_reg == GRANT0) || (state_reg == GRANT1);
  assign grant_ch = (state_reg == GRANT1);
  assign out_free = ~out_valid_reg | out_ready;
  assign sel_data = grant_ch ? in_data1 : in_data0;
  assign xfer     = granted & in_valid[grant_ch] & out_free;

  // Release conditions: LF or full burst on a transfer, or the owner idling.
  assign burst_end = xfer & ((sel_data == ASCII_LF) ||
                             (burst_cnt_reg + 8'd1 == MAX_B8));
  assign idle_end  = granted & ~in_valid[grant_ch];

  // Only the granted channel sees ready, and only when the output can take a byte.
  always_comb begin
    in_ready = 2'b00;
    if (state_reg == GRANT0) in_ready[0] = out_free;
    if (state_reg == GRANT1) in_ready[1] = out_free;
  end

  to_upper_stream_arbiter_to_upper u_to_upper (
    .din  (sel_data),
    .dout (conv_data)
  );

  // Arbitration FSM with round-robin pointer and burst length tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= 1'b0;
      burst_cnt_reg <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          case (in_valid)
            2'b01:   state_reg <= GRANT0;
            2'b10:   state_reg <= GRANT1;
            2'b11:   state_reg <= rr_ptr_reg ? GRANT1 : GRANT0;
            default: state_reg <= IDLE;
          endcase
        end
        GRANT0, GRANT1: begin
          if (burst_end || idle_end) begin
            burst_cnt_reg <= 8'd0;
            rr_ptr_reg    <= ~grant_ch;
            if (in_valid[~grant_ch]) state_reg <= grant_ch ? GRANT0 : GRANT1;
            else                     state_reg <= IDLE;
          end else if (xfer) begin
            burst_cnt_reg <= burst_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Output register: reload on transfer, otherwise clear valid once accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= 8'h00;
      out_id_reg    <= 1'b0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= conv_data;
      out_id_reg    <= grant_ch;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_id    = out_id_reg;

`ifdef UPPER_STATS_EN
  logic [CNT_W-1:0] cnt_reg [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_stats
    // Saturating count of transferred bytes that the converter changes.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg[gi] <= '0;
      end else if (xfer && (grant_ch == gi[0]) && is_lower(sel_data) &&
                   (cnt_reg[gi] != {CNT_W{1'b1}})) begin
        cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  end

  assign conv_cnt0 = cnt_reg[0];
  assign conv_cnt1 = cnt_reg[1];
`endif

endmodule

// File: tb/tb_to_upper_stream_arbiter.sv
// Self-checking bench for to_upper_stream_arbiter (UPPER_STATS_EN optional).
module tb_to_upper_stream_arbiter;

  localparam int MAXB = 16;
  localparam int CW   = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_valid;
  logic [7:0] in_data0, in_data1;
  logic [1:0] in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_id;
`ifdef UPPER_STATS_EN
  logic [CW-1:0] conv_cnt0, conv_cnt1;
`endif

  to_upper_stream_arbiter #(.MAX_BURST(MAXB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
`ifdef UPPER_STATS_EN
    ,
    .conv_cnt0 (conv_cnt0),
    .conv_cnt1 (conv_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [8:0] exp_q[$];
  int lc0, lc1;
  int cyc, first_cyc, last_cyc, n_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  // Transaction-level model: bursts alternate, each ends on LF, MAXB bytes,
  // or the owner running dry; a channel keeps the grant if the other is empty.
  task automatic build_expect();
    logic [7:0] c0[$];
    logic [7:0] c1[$];
    logic [7:0] b;
    int cur, n;
    bit done;
    c0 = q0;
    c1 = q1;
    exp_q.delete();
    cur = (c0.size() != 0) ? 0 : 1;
    while (c0.size() != 0 || c1.size() != 0) begin
      n = 0;
      done = 0;
      while (!done) begin
        if (cur == 0) b = c0.pop_front(); else b = c1.pop_front();
        exp_q.push_back({cur[0], upper(b)});
        if (b >= 8'h61 && b <= 8'h7A) begin
          if (cur == 0) lc0++; else lc1++;
        end
        n++;
        done = (b == 8'h0A) || (n == MAXB) ||
               ((cur == 0) ? (c0.size() == 0) : (c1.size() == 0));
      end
      if ((cur == 0) ? (c1.size() != 0) : (c0.size() != 0)) cur = 1 - cur;
    end
    n_exp = exp_q.size();
  endtask

  task automatic drive();
    in_valid[0] = (q0.size() != 0);
    in_valid[1] = (q1.size() != 0);
    in_data0    = (q0.size() != 0) ? q0[0] : 8'h00;
    in_data1    = (q1.size() != 0) ? q1[0] : 8'h00;
  endtask

  task automatic set_ready(input int mode);
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 9) < 7);
      default: out_ready = !(cyc >= 2 && cyc <= 6);
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
    lc0 = 0;
    lc1 = 0;
    out_ready = 1'b1;
    drive();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'h00);
    chk("rst_out_id", {31'd0, out_id}, 32'd0);
    chk("rst_in_ready", {30'd0, in_ready}, 32'd0);
  endtask

  // Runs the loaded queues to completion, checking every accepted output
  // beat against the model and the backpressure rules on every cycle.
  task automatic run_scenario(input string name, input int mode, input int limit);
    bit t0, t1, prev_stall;
    logic [7:0] prev_data;
    logic prev_id;
    logic [8:0] e;
    build_expect();
    cyc = 0;
    first_cyc = -1;
    last_cyc = -1;
    prev_stall = 0;
    prev_data = 8'h00;
    prev_id = 1'b0;
    @(posedge clk);
    #1;
    drive();
    set_ready(mode);
    while (exp_q.size() != 0 && cyc < limit) begin
      @(negedge clk);
      if (prev_stall) begin
        chk({name, "_hold_data"}, {24'd0, out_data}, {24'd0, prev_data});
        chk({name, "_hold_id"}, {31'd0, out_id}, {31'd0, prev_id});
      end
      if (out_valid && !out_ready)
        chk({name, "_stall_ready"}, {30'd0, in_ready}, 32'd0);
      t0 = in_valid[0] & in_ready[0];
      t1 = in_valid[1] & in_ready[1];
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk({name, "_data"}, {24'd0, out_data}, {24'd0, e[7:0]});
        chk({name, "_id"}, {31'd0, out_id}, {31'd0, e[8]});
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      prev_stall = out_valid & ~out_ready;
      prev_data = out_data;
      prev_id = out_id;
      @(posedge clk);
      #1;
      cyc++;
      if (t0 && q0.size() != 0) void'(q0.pop_front());
      if (t1 && q1.size() != 0) void'(q1.pop_front());
      drive();
      set_ready(mode);
    end
    chk({name, "_drained"}, exp_q.size(), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_idle_after"}, {31'd0, out_valid}, 32'd0);
`ifdef UPPER_STATS_EN
    chk({name, "_cnt0"}, {16'd0, conv_cnt0}, lc0);
    chk({name, "_cnt1"}, {16'd0, conv_cnt1}, lc1);
`endif
    $display("scenario %s: %0d beats, cycles %0d, first %0d, last %0d",
             name, n_exp, cyc, first_cyc, last_cyc);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 2'b00;
    in_data0 = 8'h00;
    in_data1 = 8'h00;
    out_ready = 1'b1;
    @(posedge clk);
    do_reset();

    // Channel 0 alone: latency 2 from IDLE, then 1 byte/cycle.
    q0 = '{8'h61, 8'h48, 8'hB7};
    run_scenario("solo0", 0, 100);
    chk("solo0_latency", first_cyc, 32'd2);
    chk("solo0_throughput", last_cyc - first_cyc, 32'd2);

    // Both valid: channel 0 first, LF hands over with no idle cycle.
    do_reset();
    q0 = '{8'h7A, 8'h0A};
    q1 = '{8'h62, 8'h63};
    run_scenario("lf_handover", 0, 100);
    chk("lf_contiguous", last_cyc - first_cyc, n_exp - 1);

    // Burst limit: channel 1 sends 20 bytes while channel 0 waits.
    do_reset();
    q0 = '{8'h0A, 8'h71};
    for (int i = 0; i < 20; i++) q1.push_back(8'h6D);
    run_scenario("max_burst", 0, 200);

    // Five-cycle stall while holding 8'h7B.
    do_reset();
    q0 = '{8'h7B, 8'h61, 8'h62};
    run_scenario("stall", 2, 100);

    // Reset mid-burst, then contested arbitration must favour channel 0.
    do_reset();
    in_valid = 2'b01;
    in_data0 = 8'h78;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 2'b11;
    in_data1 = 8'h79;
    do_reset();
    q0 = '{8'h6A, 8'h0A};
    q1 = '{8'h6B};
    run_scenario("after_rst", 0, 100);
    chk("after_rst_first_id0", first_cyc, 32'd2);

    // Conversion statistics pattern.
    do_reset();
    q0 = '{8'h61, 8'h41, 8'h7F, 8'h7A};
    run_scenario("stats", 0, 100);

    // Randomized traffic with random backpressure.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int c = 0; c < 2; c++) begin
        int len;
        len = $urandom_range(0, 40);
        for (int k = 0; k < len; k++) begin
          int sel;
          logic [7:0] b;
          sel = $urandom_range(0, 9);
          if (sel == 0)      b = 8'h0A;
          else if (sel < 6)  b = 8'($urandom_range(8'h61, 8'h7A));
          else               b = 8'($urandom_range(0, 255));
          if (c == 0) q0.push_back(b); else q1.push_back(b);
        end
      end
      run_scenario($sformatf("rand%0d", r), 1, 2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
